// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_loader
// Purpose  : Boot-time program loader. Receives a framed byte stream
//            (LEN_LO, LEN_HI, 4*N little-endian payload bytes, 8-bit
//            checksum), writes the assembled 32-bit words into instruction
//            memory and holds the CPU in reset until a checksum-valid image
//            has been written.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   re-arm pulse, honoured only in DONE / ERR
//   rx_data    in   8   incoming stream byte
//   rx_valid   in   1   rx_data valid this cycle
//   rx_ready   out  1   loader accepts a byte this cycle
//   imem_we    out  1   instruction-memory write strobe, one cycle per word
//   imem_addr  out  32  byte address of the word being written
//   imem_data  out  32  assembled instruction word
//   cpu_hold   out  1   1 = keep CPU in reset
//   done       out  1   image loaded, checksum correct
//   error      out  1   bad length or checksum mismatch
//   word_cnt   out  16  words written so far
// ============================================================================
module inst_loader #(
    parameter int          DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_cnt
);

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CSUM   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] len_q,       len_d;
    logic [1:0]  byte_idx_q,  byte_idx_d;
    logic [7:0]  sum_q,       sum_d;
    logic [31:0] word_q,      word_d;
    logic        imem_we_q,   imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_data_q, imem_data_d;
    logic [15:0] word_cnt_q,  word_cnt_d;
    logic        done_q,      done_d;
    logic        error_q,     error_d;

    logic        w_fire;
    logic [15:0] w_len_full;

    assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign w_fire     = rx_valid & rx_ready;
    assign w_len_full = {rx_data, len_q[7:0]};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        byte_idx_d  = byte_idx_q;
        sum_d       = sum_q;
        word_d      = word_q;
        imem_we_d   = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        word_cnt_d  = word_cnt_q;
        done_d      = done_q;
        error_d     = error_q;

        case (state_q)
            S_LEN_LO: begin
                if (w_fire) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_fire) begin
                    len_d[15:8] = rx_data;
                    if ((w_len_full == 16'd0) || (w_len_full > DEPTH_W)) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d    = S_DATA;
                        byte_idx_d = 2'd0;
                        sum_d      = 8'd0;
                    end
                end
            end
            S_DATA: begin
                if (w_fire) begin
                    sum_d                        = sum_q + rx_data;
                    word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
                    byte_idx_d                   = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        // Write strobe is registered: the word lands one cycle
                        // later, addressed by the pre-increment count.
                        imem_we_d   = 1'b1;
                        imem_data_d = {rx_data, word_q[23:0]};
                        imem_addr_d = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
                        word_cnt_d  = word_cnt_q + 16'd1;
                        if ((word_cnt_q + 16'd1) == len_q) begin
                            state_d = S_CSUM;
                        end
                    end
                end
            end
            S_CSUM: begin
                if (w_fire) begin
                    if (rx_data == sum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
            end
            S_DONE, S_ERR: begin
                if (start) begin
                    state_d     = S_LEN_LO;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    word_cnt_d  = 16'd0;
                    imem_addr_d = BASE_ADDR;
                    len_d       = 16'd0;
                    byte_idx_d  = 2'd0;
                    sum_d       = 8'd0;
                    word_d      = 32'd0;
                end
            end
            default: begin
                state_d = S_LEN_LO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_LEN_LO;
            len_q       <= 16'd0;
            byte_idx_q  <= 2'd0;
            sum_q       <= 8'd0;
            word_q      <= 32'd0;
            imem_we_q   <= 1'b0;
            imem_addr_q <= BASE_ADDR;
            imem_data_q <= 32'd0;
            word_cnt_q  <= 16'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            byte_idx_q  <= byte_idx_d;
            sum_q       <= sum_d;
            word_q      <= word_d;
            imem_we_q   <= imem_we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            word_cnt_q  <= word_cnt_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_we   = imem_we_q;
    assign imem_addr = imem_addr_q;
    assign imem_data = imem_data_q;
    assign word_cnt  = word_cnt_q;
    assign done      = done_q;
    assign error     = error_q;
    assign cpu_hold  = ~done_q;

endmodule
`default_nettype wire
